// File: rtl/param_frame_pkg.sv
// Shared types and constants for the parameter frame parser and the
// parameter controller it feeds (state encoding, framing bytes, parameter IDs).
package param_frame_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR2,
    ST_ID,
    ST_V3,
    ST_V2,
    ST_V1,
    ST_V0,
    ST_CSUM,
    ST_PUB
  } state_t;

  localparam logic [7:0] HDR0    = 8'h55;
  localparam logic [7:0] HDR1    = 8'hAA;
  localparam logic [7:0] ID_NONE = 8'h00;

  // Signal generator
  localparam logic [7:0] ID_SG_FREQ   = 8'h01;
  localparam logic [7:0] ID_SG_AMPL   = 8'h02;
  localparam logic [7:0] ID_SG_OFFS   = 8'h03;
  localparam logic [7:0] ID_SG_PHASE  = 8'h04;
  localparam logic [7:0] ID_SG_WAVE   = 8'h05;

  // Scope
  localparam logic [7:0] ID_SC_TBASE  = 8'h10;
  localparam logic [7:0] ID_SC_TRLVL  = 8'h11;
  localparam logic [7:0] ID_SC_TRSRC  = 8'h12;
  localparam logic [7:0] ID_SC_TREDGE = 8'h13;
  localparam logic [7:0] ID_SC_PRETRG = 8'h14;
  localparam logic [7:0] ID_SC_CH1GN  = 8'h15;
  localparam logic [7:0] ID_SC_CH2GN  = 8'h16;
  localparam logic [7:0] ID_SC_CH1OF  = 8'h17;
  localparam logic [7:0] ID_SC_CH2OF  = 8'h18;
  localparam logic [7:0] ID_SC_ARM    = 8'h19;

  // Logic analyser
  localparam logic [7:0] ID_LA_RATE   = 8'h30;
  localparam logic [7:0] ID_LA_MASK   = 8'h31;
  localparam logic [7:0] ID_LA_TRVAL  = 8'h32;
  localparam logic [7:0] ID_LA_DEPTH  = 8'h33;
  localparam logic [7:0] ID_LA_ARM    = 8'h34;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/param_frame_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// (registered) the cycle in which the count reaches TIMEOUT_CYCLES.
module param_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (en) begin
        // Hold at the limit so the flag fires once and the counter never wraps.
        if (cnt != LIMIT) cnt <= cnt + 1'b1;
        expired <= (cnt == LAST);
      end
    end
  end

endmodule

// File: rtl/param_frame_parser.sv
// Byte-stream parser assembling framed parameter writes (55 AA ID V3 V2 V1 V0 [CSUM]).
// Define PARAM_FRAME_CHECKSUM_EN to add and check the trailing checksum byte.
module param_frame_parser
  import param_frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  parameter_id,
  output logic [31:0] parameter_value,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] err_cnt
);

  state_t      state;
  logic [7:0]  shadow_id;
  logic [31:0] shadow_val;
  logic        accept;
  logic        to_en;
  logic        expired;
`ifdef PARAM_FRAME_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept = rx_valid && rx_ready;
  assign to_en  = (state != ST_IDLE) && (state != ST_PUB);

  param_frame_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (to_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      rx_ready        <= 1'b1;
      parameter_id    <= ID_NONE;
      parameter_value <= 32'h0;
      frame_ok        <= 1'b0;
      frame_err       <= 1'b0;
      err_cnt         <= 16'h0;
      shadow_id       <= ID_NONE;
      shadow_val      <= 32'h0;
`ifdef PARAM_FRAME_CHECKSUM_EN
      csum            <= 8'h0;
`endif
    end else begin
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
      parameter_id <= ID_NONE;
      rx_ready     <= 1'b1;
      if (state == ST_PUB) begin
        state <= ST_IDLE;
      end else if (accept) begin
        case (state)
          ST_IDLE: if (rx_data == HDR0) state <= ST_HDR2;
          ST_HDR2: begin
            if (rx_data == HDR1)      state <= ST_ID;
            else if (rx_data != HDR0) state <= ST_IDLE;
          end
          ST_ID: begin
            shadow_id <= rx_data;
`ifdef PARAM_FRAME_CHECKSUM_EN
            csum      <= rx_data;
`endif
            state     <= ST_V3;
          end
          ST_V3: begin
            shadow_val[31:24] <= rx_data;
`ifdef PARAM_FRAME_CHECKSUM_EN
            csum              <= csum + rx_data;
`endif
            state             <= ST_V2;
          end
          ST_V2: begin
            shadow_val[23:16] <= rx_data;
`ifdef PARAM_FRAME_CHECKSUM_EN
            csum              <= csum + rx_data;
`endif
            state             <= ST_V1;
          end
          ST_V1: begin
            shadow_val[15:8] <= rx_data;
`ifdef PARAM_FRAME_CHECKSUM_EN
            csum             <= csum + rx_data;
`endif
            state            <= ST_V0;
          end
          ST_V0: begin
            shadow_val[7:0] <= rx_data;
`ifdef PARAM_FRAME_CHECKSUM_EN
            csum            <= csum + rx_data;
            state           <= ST_CSUM;
`else
            if (shadow_id != ID_NONE) begin
              parameter_id    <= shadow_id;
              parameter_value <= {shadow_val[31:8], rx_data};
              frame_ok        <= 1'b1;
              rx_ready        <= 1'b0;
              state           <= ST_PUB;
            end else begin
              frame_err <= 1'b1;
              err_cnt   <= sat_inc16(err_cnt);
              state     <= ST_IDLE;
            end
`endif
          end
`ifdef PARAM_FRAME_CHECKSUM_EN
          ST_CSUM: begin
            if (rx_data == csum && shadow_id != ID_NONE) begin
              parameter_id    <= shadow_id;
              parameter_value <= shadow_val;
              frame_ok        <= 1'b1;
              rx_ready        <= 1'b0;
              state           <= ST_PUB;
            end else begin
              frame_err <= 1'b1;
              err_cnt   <= sat_inc16(err_cnt);
              state     <= ST_IDLE;
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end else if (expired) begin
        // A byte arriving in the expiry cycle takes the accept branch above instead.
        frame_err  <= 1'b1;
        err_cnt    <= sat_inc16(err_cnt);
        shadow_id  <= ID_NONE;
        shadow_val <= 32'h0;
        state      <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_param_frame_parser.sv
// Self-checking bench for param_frame_parser: directed test-plan frames plus
// randomized byte streams checked every cycle against a frame-level model.
module tb_param_frame_parser;

  localparam int T = 16;
`ifdef PARAM_FRAME_CHECKSUM_EN
  localparam bit CS   = 1'b1;
  localparam int FLEN = 8;
`else
  localparam bit CS   = 1'b0;
  localparam int FLEN = 7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  parameter_id;
  logic [31:0] parameter_value;
  logic        frame_ok;
  logic        frame_err;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  param_frame_parser #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .parameter_id    (parameter_id),
    .parameter_value (parameter_value),
    .frame_ok        (frame_ok),
    .frame_err       (frame_err),
    .err_cnt         (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the frame collected so far, idle gap inside a
  // frame, and the expected registered outputs.
  logic [7:0]  fq[$];
  int          gap = 0;
  bit          pub = 0;
  logic [7:0]  e_id = 8'h00;
  logic [31:0] e_val = 32'h0;
  logic        e_ok = 0, e_err = 0, e_ready = 1;
  logic [15:0] e_cnt = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void bump_err();
    e_err = 1;
    if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 1;
  endfunction

  function automatic void model(input bit r, input bit v, input logic [7:0] d);
    logic [7:0] id;
    logic [31:0] val;
    int sum;
    if (r) begin
      fq.delete(); gap = 0; pub = 0;
      e_id = 0; e_val = 0; e_ok = 0; e_err = 0; e_ready = 1; e_cnt = 0;
      return;
    end
    e_id = 0; e_ok = 0; e_err = 0;
    if (pub) begin
      pub = 0; e_ready = 1;
      return;
    end
    if (v) begin
      gap = 0;
      if (fq.size() == 0) begin
        if (d == 8'h55) fq.push_back(d);
      end else if (fq.size() == 1) begin
        if (d == 8'hAA) fq.push_back(d);
        else if (d != 8'h55) fq.delete();
      end else begin
        fq.push_back(d);
        if (fq.size() == FLEN) begin
          id  = fq[2];
          val = {fq[3], fq[4], fq[5], fq[6]};
          sum = (fq[2] + fq[3] + fq[4] + fq[5] + fq[6]) % 256;
          if (id != 0 && (!CS || fq[FLEN-1] == sum[7:0])) begin
            e_id = id; e_val = val; e_ok = 1; e_ready = 0; pub = 1;
          end else bump_err();
          fq.delete();
        end
      end
    end else if (fq.size() > 0) begin
      gap++;
      if (gap > T) begin
        bump_err(); fq.delete(); gap = 0;
      end
    end
  endfunction

  task automatic step(input bit r, input bit v, input logic [7:0] d);
    rst = r; rx_valid = v; rx_data = d;
    model(r, v, d);
    @(posedge clk);
    @(negedge clk);
    chk("rx_ready", rx_ready, e_ready);
    chk("parameter_id", parameter_id, e_id);
    chk("parameter_value", parameter_value, e_val);
    chk("frame_ok", frame_ok, e_ok);
    chk("frame_err", frame_err, e_err);
    chk("err_cnt", err_cnt, e_cnt);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit was_ready = 0;
    for (int k = 0; k < 4 && !was_ready; k++) begin
      was_ready = e_ready;
      step(0, 1, b);
    end
    if (!was_ready) chk("accept_bound", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [31:0] val,
                            input bit bad, input int maxgap);
    logic [7:0] b[8];
    logic [7:0] s;
    b[0] = 8'h55; b[1] = 8'hAA; b[2] = id;
    b[3] = val[31:24]; b[4] = val[23:16]; b[5] = val[15:8]; b[6] = val[7:0];
    s = b[2] + b[3] + b[4] + b[5] + b[6];
    b[7] = bad ? s ^ 8'h01 : s;
    for (int k = 0; k < FLEN; k++) begin
      if (maxgap > 0) idle($urandom_range(maxgap));
      send_byte(b[k]);
    end
  endtask

  logic [7:0] ids[8] = '{8'h01, 8'h05, 8'h10, 8'h19, 8'h13, 8'h30, 8'h34, 8'h02};

  initial begin
    @(negedge clk);
    // Reset with bytes presented: all ignored, outputs at reset values.
    for (int k = 0; k < 3; k++) step(1, 1, 8'h55);
    chk("rst_ready", rx_ready, 1);
    chk("rst_id", parameter_id, 0);

    // Basic frame.
    send_frame(8'h01, 32'h00053E6D, 0, 0);
    chk("f1_id", parameter_id, 8'h01);
    chk("f1_val", parameter_value, 32'h00053E6D);
    chk("f1_ok", frame_ok, 1);
    step(0, 0, 8'h00);
    chk("f1_id_clr", parameter_id, 8'h00);

    // Bad checksum, or reserved ID when the checksum byte does not exist.
    if (CS) send_frame(8'h01, 32'h00053E6D, 1, 0);
    else    send_frame(8'h00, 32'h00053E6D, 0, 0);
    chk("bad_err", frame_err, 1);
    chk("bad_id", parameter_id, 8'h00);
    chk("bad_val", parameter_value, 32'h00053E6D);
    chk("bad_cnt", err_cnt, 16'd1);
    idle(2);

    // Resync on repeated header byte.
    send_byte(8'h55);
    send_frame(8'h34, 32'h1, 0, 0);
    chk("resync_id", parameter_id, 8'h34);
    chk("resync_val", parameter_value, 32'h1);
    idle(1);

    // Timeout mid-frame, then a good frame.
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h30);
    idle(T + 1);
    chk("to_err", frame_err, 1);
    chk("to_cnt", err_cnt, 16'd2);
    send_frame(8'h30, 32'd20000, 0, 0);
    chk("to_id", parameter_id, 8'h30);
    chk("to_val", parameter_value, 32'd20000);
    idle(1);

    // A byte landing in the expiry cycle wins.
    send_byte(8'h55); send_byte(8'hAA);
    idle(T);
    send_byte(8'h10);
    chk("edge_cnt", err_cnt, 16'd2);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    if (CS) send_byte(8'h17);
    chk("edge_id", parameter_id, 8'h10);

    // Back-to-back frames with rx_valid held high.
    send_frame(8'h11, 32'hDEADBEEF, 0, 0);
    chk("b2b_a", parameter_id, 8'h11);
    chk("b2b_ready", rx_ready, 0);
    send_frame(8'h12, 32'h01234567, 0, 0);
    chk("b2b_b", parameter_id, 8'h12);

    // Reset mid-frame.
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h15);
    send_byte(8'h00); send_byte(8'h00);
    step(1, 1, 8'h00); step(1, 1, 8'h00);
    chk("mrst_val", parameter_value, 32'h0);
    chk("mrst_cnt", err_cnt, 16'd0);
    send_frame(8'h16, 32'hCAFEF00D, 0, 0);
    chk("mrst_id", parameter_id, 8'h16);
    chk("mrst_ok", frame_ok, 1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(9))
        0, 1, 2: send_frame(ids[$urandom_range(7)], $urandom, 0, 0);
        3, 4:    send_frame(ids[$urandom_range(7)], $urandom, 0, 3);
        5:       send_frame(ids[$urandom_range(7)], $urandom, CS, 1);
        6:       send_frame(8'h00, $urandom, 0, 0);
        7:       for (int k = 0; k < 4; k++) send_byte(($urandom_range(3) == 0) ? 8'h55 : 8'($urandom));
        8:       idle($urandom_range(T + 2));
        default: begin
          if ($urandom_range(3) == 0) step(1, 1, 8'h55);
          else send_frame(ids[$urandom_range(7)], $urandom, 0, T + 1);
        end
      endcase
    end
    idle(T + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
